// File: rtl/blur_img_stream.sv
// Streaming 3x3 Gaussian blur (1-2-1 / 2-4-2 / 1-2-1, /16) between a source and a destination BRAM.
// Define BLUR_ROUND_EN for round-half-up output; default build truncates.
module blur_img_stream #(
  parameter int unsigned BIT_DEPTH    = 8,
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned HEIGHT       = 64,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_read_addr,
  output logic                            ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]            ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_write_addr,
  output logic                            ext_write_valid,
  output logic [BIT_DEPTH-1:0]            ext_pixel_out,
  input  logic                            start_in,
  output logic                            busy_out,
  output logic                            blur_done
);
  localparam int unsigned AW = $clog2(WIDTH*HEIGHT);
  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned SW = BIT_DEPTH + 4;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  typedef struct packed {
    logic          v;
    logic [1:0]    slot;
    logic          pre;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } tag_t;

  state_e        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic          pre_q, pre_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_rd, last_wr;
  logic [YW-1:0] row;
  logic [XW-1:0] col;

  assign last_rd = (slot_q == 2'd2) && !pre_q && (x_q == XW'(WIDTH - 1)) &&
                   (y_q == YW'(HEIGHT - 1));
  assign last_wr = ext_write_valid && (ext_write_addr == AW'(WIDTH * HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pre_d   = pre_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StFetch;
          slot_d  = 2'd0;
          pre_d   = 1'b1;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StFetch: begin
        if (slot_q != 2'd2) begin
          slot_d = slot_q + 2'd1;
        end else begin
          slot_d = 2'd0;
          if (pre_q) begin
            pre_d = 1'b0;
          end else if (x_q != XW'(WIDTH - 1)) begin
            x_d = x_q + XW'(1);
          end else begin
            x_d   = '0;
            pre_d = 1'b1;
            y_d   = y_q + YW'(1);
          end
        end
        if (last_rd) state_d = StDrain;
      end
      StDrain: if (last_wr) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      slot_q  <= 2'd0;
      pre_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pre_q   <= pre_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Clamped source coordinates: rows y-1/y/y+1 by slot, column 0 on preload else x+1.
  always_comb begin
    row = y_q;
    col = '0;
    unique case (slot_q)
      2'd0:    row = (y_q == '0) ? '0 : y_q - YW'(1);
      2'd2:    row = (y_q == YW'(HEIGHT - 1)) ? y_q : y_q + YW'(1);
      default: row = y_q;
    endcase
    if (!pre_q) col = (x_q == XW'(WIDTH - 1)) ? x_q : x_q + XW'(1);
  end

  assign ext_read_addr_valid = (state_q == StFetch);
  assign ext_read_addr       = ext_read_addr_valid ? AW'(row) * AW'(WIDTH) + AW'(col) : '0;
  assign busy_out            = (state_q != StIdle);
  assign blur_done           = (state_q == StDone);

  tag_t tag_q [READ_LATENCY];
  tag_t rt;
  assign rt = tag_q[READ_LATENCY-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {ext_read_addr_valid, slot_q, pre_q, x_q, y_q};
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Columns are packed [2]=top, [1]=middle, [0]=bottom.
  logic [BIT_DEPTH-1:0]      col_t_q, col_m_q;
  logic [2:0][BIT_DEPTH-1:0] win_l_q, win_c_q, new_col;
  logic [2:0][BIT_DEPTH-1:0] k_l_q, k_c_q, k_r_q;
  logic                      k_valid_q;
  logic [XW-1:0]             k_x_q;
  logic [YW-1:0]             k_y_q;

  assign new_col = {col_t_q, col_m_q, ext_pixel_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col_t_q   <= '0;
      col_m_q   <= '0;
      win_l_q   <= '0;
      win_c_q   <= '0;
      k_l_q     <= '0;
      k_c_q     <= '0;
      k_r_q     <= '0;
      k_valid_q <= 1'b0;
      k_x_q     <= '0;
      k_y_q     <= '0;
    end else begin
      k_valid_q <= 1'b0;
      if (rt.v) begin
        unique case (rt.slot)
          2'd0: col_t_q <= ext_pixel_in;
          2'd1: col_m_q <= ext_pixel_in;
          default: begin
            if (rt.pre) begin
              win_l_q <= new_col;
              win_c_q <= new_col;
            end else begin
              k_l_q     <= win_l_q;
              k_c_q     <= win_c_q;
              k_r_q     <= new_col;
              k_x_q     <= rt.x;
              k_y_q     <= rt.y;
              k_valid_q <= 1'b1;
              win_l_q   <= win_c_q;
              win_c_q   <= new_col;
            end
          end
        endcase
      end
    end
  end

  logic [SW-1:0]        sum, sum_r;
  logic [BIT_DEPTH-1:0] pix;

  always_comb begin
    sum = SW'(k_l_q[2]) + SW'(k_l_q[0]) + SW'(k_r_q[2]) + SW'(k_r_q[0])
        + ((SW'(k_l_q[1]) + SW'(k_r_q[1]) + SW'(k_c_q[2]) + SW'(k_c_q[0])) << 1)
        + (SW'(k_c_q[1]) << 2);
`ifdef BLUR_ROUND_EN
    sum_r = sum + SW'(8);
`else
    sum_r = sum;
`endif
    pix = BIT_DEPTH'(sum_r >> 4);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ext_write_valid <= 1'b0;
      ext_write_addr  <= '0;
      ext_pixel_out   <= '0;
    end else begin
      ext_write_valid <= k_valid_q;
      if (k_valid_q) begin
        ext_write_addr <= AW'(k_x_q) + AW'(k_y_q) * AW'(WIDTH);
        ext_pixel_out  <= pix;
      end
    end
  end

endmodule

// File: tb/tb_blur_img_stream.sv
// Self-checking bench for blur_img_stream: 64x64/latency-2 and 5x3/latency-1 instances.
module tb_blur_img_stream;
  localparam int BD = 8;
  localparam int WA = 64, HA = 64, LA = 2;
  localparam int WB = 5, HB = 3, LB = 1;
  localparam int AWA = $clog2(WA * HA);
  localparam int AWB = $clog2(WB * HB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AWA-1:0] a_raddr, a_waddr;
  logic           a_rv, a_wv, a_start, a_busy, a_done;
  logic [BD-1:0]  a_pin, a_pout;
  logic [AWB-1:0] b_raddr, b_waddr;
  logic           b_rv, b_wv, b_start, b_busy, b_done;
  logic [BD-1:0]  b_pin, b_pout;

  blur_img_stream #(.BIT_DEPTH(BD), .WIDTH(WA), .HEIGHT(HA), .READ_LATENCY(LA)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .ext_read_addr(a_raddr), .ext_read_addr_valid(a_rv),
    .ext_pixel_in(a_pin), .ext_write_addr(a_waddr), .ext_write_valid(a_wv),
    .ext_pixel_out(a_pout), .start_in(a_start), .busy_out(a_busy), .blur_done(a_done)
  );

  blur_img_stream #(.BIT_DEPTH(BD), .WIDTH(WB), .HEIGHT(HB), .READ_LATENCY(LB)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .ext_read_addr(b_raddr), .ext_read_addr_valid(b_rv),
    .ext_pixel_in(b_pin), .ext_write_addr(b_waddr), .ext_write_valid(b_wv),
    .ext_pixel_out(b_pout), .start_in(b_start), .busy_out(b_busy), .blur_done(b_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int img_a [WA*HA];
  int img_b [WB*HB];
  int out_a [WA*HA];
  int out_b [WB*HB];

  // Source BRAM models: data appears exactly the read latency after its strobe.
  logic [BD-1:0] a_pipe [LA];
  logic [BD-1:0] b_pipe [LB];
  always @(posedge clk) begin
    a_pipe[0] <= a_rv ? BD'(img_a[a_raddr]) : 8'hEE;
    for (int i = 1; i < LA; i++) a_pipe[i] <= a_pipe[i-1];
    b_pipe[0] <= (b_rv && int'(b_raddr) < WB * HB) ? BD'(img_b[b_raddr]) : 8'hEE;
  end
  assign a_pin = a_pipe[LA-1];
  assign b_pin = b_pipe[LB-1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int n);
    return (v < 0) ? 0 : ((v >= n) ? n - 1 : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference blur: clamped 3x3 weighted sum with weights (2-|dx|)*(2-|dy|).
  function automatic int model(input bit use_b, input int x, input int y);
    int s, w, h, xx, yy;
    s = 0;
    w = use_b ? WB : WA;
    h = use_b ? HB : HA;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = clampi(x + dx, w);
        yy = clampi(y + dy, h);
        s += (2 - absi(dx)) * (2 - absi(dy)) * (use_b ? img_b[yy*w+xx] : img_a[yy*w+xx]);
      end
    end
`ifdef BLUR_ROUND_EN
    s += 8;
`endif
    return s / 16;
  endfunction

  // k-th read address: per row, 3 preload reads of column 0, then 3 reads of column x+1.
  function automatic int rd_exp(input int k, input int w, input int h);
    int per, y, r, c;
    per = 3 * w + 3;
    y = k / per;
    r = k % per;
    c = (r < 3) ? 0 : clampi((r - 3) / 3 + 1, w);
    return clampi(y + (r % 3) - 1, h) * w + c;
  endfunction

  bit a_on = 0, b_on = 0;
  int a_s0, a_rd, a_wr, a_first_rd, a_last_rd, a_first_wr, a_last_wr;
  int b_s0, b_rd, b_wr, b_first_rd, b_last_rd, b_first_wr, b_last_wr;

  always @(negedge clk) begin
    if (a_on) begin
      if (a_rv) begin
        if (a_rd == 0) a_first_rd = cyc - a_s0;
        a_last_rd = cyc - a_s0;
        chk("a_read_addr", int'(a_raddr), rd_exp(a_rd, WA, HA));
        a_rd++;
      end
      if (a_wv) begin
        if (a_wr == 0) a_first_wr = cyc - a_s0;
        a_last_wr = cyc - a_s0;
        if (a_wr < WA * HA) begin
          chk("a_write_addr", int'(a_waddr), a_wr);
          chk("a_write_pixel", int'(a_pout), model(1'b0, a_wr % WA, a_wr / WA));
          out_a[a_wr] = int'(a_pout);
        end else begin
          chk("a_extra_write", a_wr, WA * HA - 1);
        end
        a_wr++;
      end
    end
    if (b_on) begin
      if (b_rv) begin
        if (b_rd == 0) b_first_rd = cyc - b_s0;
        b_last_rd = cyc - b_s0;
        chk("b_read_addr", int'(b_raddr), rd_exp(b_rd, WB, HB));
        b_rd++;
      end
      if (b_wv) begin
        if (b_wr == 0) b_first_wr = cyc - b_s0;
        b_last_wr = cyc - b_s0;
        if (b_wr < WB * HB) begin
          chk("b_write_addr", int'(b_waddr), b_wr);
          chk("b_write_pixel", int'(b_pout), model(1'b1, b_wr % WB, b_wr / WB));
          out_b[b_wr] = int'(b_pout);
        end else begin
          chk("b_extra_write", b_wr, WB * HB - 1);
        end
        b_wr++;
      end
    end
  end

  task automatic clear_a();
    a_s0 = cyc; a_rd = 0; a_wr = 0;
    a_first_rd = -1; a_last_rd = -1; a_first_wr = -1; a_last_wr = -1;
    for (int i = 0; i < WA * HA; i++) out_a[i] = -1;
  endtask

  // Returns cycle of blur_done relative to start, or -1 on timeout.
  task automatic wait_a_done(output int rel);
    int n;
    n = 0;
    while (!a_done && n < 13000) begin
      @(negedge clk);
      n++;
    end
    if (a_done) begin
      rel = cyc - a_s0;
    end else begin
      rel = -1;
      chk("a_done_timeout", 0, 1);
    end
  endtask

  task automatic check_a_run(input string tag, input int done_rel);
    chk({tag, "_reads"}, a_rd, 12480);
    chk({tag, "_first_read_cycle"}, a_first_rd, 1);
    chk({tag, "_last_read_cycle"}, a_last_rd, 12480);
    chk({tag, "_writes"}, a_wr, 4096);
    chk({tag, "_first_write_cycle"}, a_first_wr, 10);
    chk({tag, "_last_write_cycle"}, a_last_wr, 12484);
    chk({tag, "_done_cycle"}, done_rel, 12485);
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_read_addr"}, int'(a_raddr), 0);
    chk({tag, "_read_valid"}, int'(a_rv), 0);
    chk({tag, "_write_addr"}, int'(a_waddr), 0);
    chk({tag, "_write_valid"}, int'(a_wv), 0);
    chk({tag, "_pixel_out"}, int'(a_pout), 0);
    chk({tag, "_busy"}, int'(a_busy), 0);
    chk({tag, "_done"}, int'(a_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int rel, n, nz, seen;
    a_start = 0;
    b_start = 0;
    for (int i = 0; i < WA * HA; i++) img_a[i] = 100;
    for (int i = 0; i < WB * HB; i++) img_b[i] = i;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    chk("b_reset_busy", int'(b_busy), 0);
    rst_n = 1;
    @(negedge clk);

    // Small ramp image on the 5x3, latency-1 instance.
    b_s0 = cyc; b_rd = 0; b_wr = 0; b_on = 1; b_start = 1;
    @(negedge clk);
    b_start = 0;
    n = 0;
    while (!b_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    rel = b_done ? cyc - b_s0 : -1;
    chk("b_done_cycle", rel, 58);
    @(negedge clk);
    b_on = 0;
    chk("b_busy_after_done", int'(b_busy), 0);
    chk("b_reads", b_rd, 54);
    chk("b_read_span", b_last_rd - b_first_rd + 1, 54);
    chk("b_writes", b_wr, 15);
    chk("b_last_write_cycle", b_last_wr, 57);
    chk("b_out_1_1", out_b[6], 6);
    chk("b_out_2_1", out_b[7], 7);
    chk("b_out_2_0", out_b[2], 3);

    // Constant image on the 64x64 instance, with exact timing.
    @(negedge clk);
    clear_a();
    a_on = 1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    chk("a_busy_cycle1", int'(a_busy), 1);
    chk("a_read_valid_cycle1", int'(a_rv), 1);
    wait_a_done(rel);
    check_a_run("const", rel);
    chk("const_out_0_0", out_a[0], 100);
    chk("const_out_63_63", out_a[4095], 100);

    // Start while blur_done is high is ignored; start on the next cycle is accepted.
    for (int i = 0; i < WA * HA; i++) img_a[i] = 0;
    img_a[0] = 16;
    img_a[5*WA+5] = 2;
    img_a[10*WA+10] = 160;
    a_start = 1;
    @(negedge clk);
    chk("start_during_done_busy", int'(a_busy), 0);
    chk("start_during_done_read", int'(a_rv), 0);
    clear_a();
    @(negedge clk);
    a_start = 0;
    chk("start_after_done_read", int'(a_rv), 1);
    wait_a_done(rel);
    check_a_run("impulse", rel);
    chk("imp_10_10", out_a[10*WA+10], 40);
    chk("imp_9_10", out_a[10*WA+9], 20);
    chk("imp_10_11", out_a[11*WA+10], 20);
    chk("imp_9_9", out_a[9*WA+9], 10);
    chk("imp_11_11", out_a[11*WA+11], 10);
    chk("corner_0_0", out_a[0], 9);
    chk("corner_1_0", out_a[1], 3);
    chk("corner_1_1", out_a[WA+1], 1);
    chk("corner_0_1", out_a[WA], 3);
`ifdef BLUR_ROUND_EN
    chk("small_5_5", out_a[5*WA+5], 1);
`else
    chk("small_5_5", out_a[5*WA+5], 0);
`endif
    chk("small_4_5", out_a[5*WA+4], 0);
    nz = 0;
    for (int i = 0; i < WA * HA; i++) if (out_a[i] != 0) nz++;
`ifdef BLUR_ROUND_EN
    chk("impulse_nonzero", nz, 14);
`else
    chk("impulse_nonzero", nz, 13);
`endif

    // Mid-image reset with an ignored second start at cycle 100.
    repeat (3) @(negedge clk);
    for (int i = 0; i < WA * HA; i++) img_a[i] = int'($urandom_range(0, 255));
    clear_a();
    a_on = 1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    while (cyc - a_s0 < 100) @(negedge clk);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    while (cyc - a_s0 < 500) @(negedge clk);
    a_on = 0;
    rst_n = 0;
    #1;
    check_a_zero("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_wv || a_rv) seen++;
    end
    chk("quiet_after_reset", seen, 0);

    // Fresh start after reset yields a full correct image.
    for (int i = 0; i < WA * HA; i++) img_a[i] = int'($urandom_range(0, 255));
    clear_a();
    a_on = 1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    wait_a_done(rel);
    check_a_run("after_reset", rel);
    @(negedge clk);
    a_on = 0;
    chk("after_reset_busy_low", int'(a_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
